// File: rtl/led_frame_arbiter.sv
// Round-robin arbiter that feeds 5-LED GRB frames from two requesters to a WS2812B
// strip sender, with a send watchdog and an inter-frame latch gap.
module led_frame_arbiter #(
  parameter int unsigned LATCH_CYCLES = 15000,
  parameter int unsigned TX_TIMEOUT   = 200000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [119:0] grb0,
  input  logic [119:0] grb1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [119:0] frameGRB,
  output logic         sendStart,
  input  logic         sendDone,
  output logic         ready,
  output logic         txError
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam logic [19:0] TX_LAST    = 20'(TX_TIMEOUT - 1);
  localparam logic [19:0] LATCH_LAST = 20'(LATCH_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [19:0] cnt;
  logic        last_grant;
  logic        winner;
  logic        winner_nxt;
  logic        done_ok;
  logic        timeout;

  // A done report in the sendStart cycle is stale and must not end the frame.
  assign done_ok    = sendDone && (cnt != '0);
  assign timeout    = (cnt == TX_LAST);
  assign winner_nxt = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_nxt = GRANT;
      GRANT:   state_nxt = SEND;
      SEND:    if (done_ok || timeout) state_nxt = LATCH;
      LATCH:   if (cnt == LATCH_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    gnt0      = (state == GRANT) && !winner;
    gnt1      = (state == GRANT) &&  winner;
    sendStart = (state == SEND) && (cnt == '0);
  end

  // Counter restarts on every state change so SEND and LATCH each time from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      frameGRB   <= '0;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      txError    <= 1'b0;
    end else begin
      if (state != state_nxt)
        cnt <= '0;
      else if (state == SEND || state == LATCH)
        cnt <= cnt + 20'd1;
      if (state == IDLE)
        winner <= winner_nxt;
      if (state == GRANT) begin
        frameGRB   <= winner ? grb1 : grb0;
        last_grant <= winner;
      end
      if (state == SEND && timeout && !done_ok)
        txError <= 1'b1;
    end
  end

endmodule
